shift_rows_stage: RTL and testbench
===================================

# shift_rows_stage

Row-rotation stage of the encryption core, sitting directly downstream of `sbox`. It accepts one character matrix plus its row mask per transaction from the sbox output and cyclically rotates each enabled row `i` by `i` positions, processing one row per clock. It then holds the result under a valid/ready handshake for the next round stage (mix-columns).

## Interface
- `ROWS`, 16, matrix rows; also the width of the row mask.
- `COLS`, 16, matrix columns.
- `CHAR_W`, 16, bits per character.
- `SHIFT_DIR`, 0, rotation direction: 0 = left (encrypt), 1 = right (inverse cipher).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `shift_ip_char_matrix`  in  CHAR_W x [ROWS][COLS]  matrix from `sbox_op_char_matrix`.
- `shift_ip_char_row_mask`  in  ROWS  bit `i` = 1 rotates row `i`; 0 copies row `i` unchanged.
- `shift_ip_valid`  in  1  input matrix valid (from `sbox_op_char_matrix_valid`).
- `shift_ip_ready`  out  1  stage can capture an input this cycle.
- `shift_op_char_matrix`  out  CHAR_W x [ROWS][COLS]  rotated matrix, registered.
- `shift_op_char_row_mask`  out  ROWS  copy of the captured mask.
- `shift_op_valid`  out  1  output matrix valid.
- `shift_op_ready`  in  1  downstream accepts the output.
- `shift_busy`  out  1  high while the stage is in SHIFT.

## Operation
- Storage: a captured input matrix and mask (`in_reg`, `mask_reg`), the output matrix register, and a row counter `row_cnt` of width clog2(ROWS).
- State machine:
  - IDLE:
    - `shift_ip_ready` = 1.
    - On `shift_ip_valid`: capture the matrix and mask, set `row_cnt` = 0, go to SHIFT.
  - SHIFT:
    - `shift_ip_ready` = 0 and `shift_busy` = 1.
    - Each cycle write output row `row_cnt`:
      - if `mask_reg[row_cnt]`: left shift gives out[r][j] = in[r][(j + r) mod COLS]; right shift gives out[r][j] = in[r][(j - r + COLS) mod COLS].
      - otherwise out[r][j] = in[r][j].
    - Increment `row_cnt`. After row ROWS-1, go to HOLD.
  - HOLD:
    - `shift_op_valid` = 1. The output matrix and mask are stable.
    - `shift_ip_ready` = `shift_op_ready`.
    - On `shift_op_ready`: if `shift_ip_valid`, capture the new input and go to SHIFT (back-to-back); otherwise go to IDLE.
- The rotation amount is r mod COLS. Row 0 is never rotated.
- A mask of all zeros still runs the full ROWS-cycle SHIFT pass; latency never depends on the data or the mask.
- Inputs are ignored outside the capture handshake.
- `shift_op_char_matrix` keeps its last value in IDLE. Rows are overwritten progressively during SHIFT while `shift_op_valid` = 0.

## Timing
- Reset values while `reset` is high and after release:
  - state IDLE, `row_cnt` 0;
  - `shift_op_char_matrix` all 0, `shift_op_char_row_mask` 0;
  - `shift_op_valid` 0, `shift_busy` 0.
  - `shift_ip_ready` is forced 0 while `reset` is high and is 1 from the first cycle after release.
- Capture at edge T. Row k is written at edge T+1+k. HOLD is entered at edge T+ROWS. `shift_op_valid` rises right after edge T+ROWS, giving a latency of ROWS (16) cycles.
- Output transfer occurs at an edge where `shift_op_valid` and `shift_op_ready` are both high.
- Peak throughput is one matrix per ROWS+1 cycles, using the back-to-back capture in HOLD.
- Backpressure: HOLD persists indefinitely. The output and `shift_ip_ready` = 0 remain stable for as long as `shift_op_ready` = 0.
- Reset mid-SHIFT or mid-HOLD: outputs clear asynchronously, the partial matrix is discarded, and nothing is emitted.
- Simultaneous `shift_op_ready` and `shift_ip_valid` in HOLD: the old output is accepted and the new input captured on the same edge, with no bubble.

## Test plan
- Reset check: assert `reset` for 20 ns with random inputs -> all outputs 0 and `shift_ip_ready` 0. After release, `shift_ip_ready` = 1 and `shift_op_valid` stays 0.
- Full mask 16'hFFFF, in[i][j] = 10*i+j, `shift_op_ready` = 1 -> `shift_op_valid` exactly 16 cycles after capture:
  - out[0][0] = 0, out[1][0] = 11, out[1][15] = 10;
  - out[15][0] = 165, out[15][1] = 150;
  - output mask = 16'hFFFF.
- Mask 16'h0001, same data -> output equals input (row 0 is unrotated). Mask 16'h0002 -> only row 1 rotated: out[1][0] = 11, out[2][0] = 20.
- Backpressure: hold `shift_op_ready` = 0 for 5 cycles in HOLD -> output, mask and `shift_op_valid` stable, `shift_ip_ready` = 0. Then raise `shift_op_ready` with `shift_ip_valid` high -> the next matrix is captured on the same edge, and the next valid follows 16 cycles later.
- Reset pulse when `row_cnt` = 7 -> `shift_op_valid` never rises for that matrix and outputs read 0. A fresh transaction afterwards produces the correct result.
- `SHIFT_DIR` = 1, full mask, in[i][j] = 10*i+j -> out[1][0] = 25, out[2][0] = 34, out[15][0] = 151.

Source files
------------

// File: rtl/shift_rows_stage.sv
// ---------------------------------------------------------------------------
// shift_rows_stage
//
// Row-rotation stage of the encryption core. It captures one character
// matrix and its row mask, then rotates each enabled row r cyclically by
// (r mod COLS) positions, producing one output row per clock. The finished
// matrix is held under a valid/ready handshake for the mix-columns stage.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   asynchronous, active-high reset
//   shift_ip_char_matrix    input matrix [ROWS][COLS] of CHAR_W-bit chars
//   shift_ip_char_row_mask  bit r = 1 rotates row r, 0 copies it unchanged
//   shift_ip_valid          input matrix valid
//   shift_ip_ready          stage can capture an input this cycle
//   shift_op_char_matrix    rotated matrix (registered)
//   shift_op_char_row_mask  copy of the captured mask (registered)
//   shift_op_valid          output matrix valid
//   shift_op_ready          downstream accepts the output
//   shift_busy              high while rows are being rotated
// ---------------------------------------------------------------------------
module shift_rows_stage #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int CHAR_W    = 16,
    parameter int SHIFT_DIR = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0] shift_ip_char_matrix,
    input  logic [ROWS-1:0]                       shift_ip_char_row_mask,
    input  logic                                  shift_ip_valid,
    output logic                                  shift_ip_ready,
    output logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0] shift_op_char_matrix,
    output logic [ROWS-1:0]                       shift_op_char_row_mask,
    output logic                                  shift_op_valid,
    input  logic                                  shift_op_ready,
    output logic                                  shift_busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                                state;
    state_t                                state_nxt;
    logic                                  ready_core;
    logic                                  capture;
    logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0] in_reg;
    logic [ROWS-1:0]                       mask_reg;
    logic [RW-1:0]                         row_cnt;
    logic [COLS-1:0][CHAR_W-1:0]           rot_row;
    int                                    amt;
    logic [CW-1:0]                         src;

    // Next-state logic and capture handshake.
    always_comb begin
        state_nxt  = state;
        ready_core = 1'b0;
        case (state)
            IDLE: begin
                ready_core = 1'b1;
                if (shift_ip_valid) begin
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (row_cnt == LAST_ROW) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            HOLD: begin
                // Accepting the old result frees the stage for a new capture
                // on the very same edge, so ready follows downstream ready.
                ready_core = shift_op_ready;
                if (shift_op_ready) begin
                    if (shift_ip_valid) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt  = IDLE;
                ready_core = 1'b0;
            end
        endcase
    end

    assign capture        = ready_core & shift_ip_valid;
    // Ready is forced low for the whole time reset is asserted.
    assign shift_ip_ready = ready_core & ~reset;

    // Rotated version of the row currently addressed by row_cnt.
    always_comb begin
        amt     = int'(row_cnt) % COLS;
        src     = '0;
        rot_row = '0;
        for (int j = 0; j < COLS; j++) begin
            if (SHIFT_DIR == 0) begin
                src = CW'((j + amt) % COLS);
            end else begin
                src = CW'((j - amt + COLS) % COLS);
            end
            if (mask_reg[row_cnt]) begin
                rot_row[CW'(j)] = in_reg[row_cnt][src];
            end else begin
                rot_row[CW'(j)] = in_reg[row_cnt][CW'(j)];
            end
        end
    end

    // State register with valid/busy flags registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shift_op_valid <= 1'b0;
            shift_busy     <= 1'b0;
        end else begin
            state          <= state_nxt;
            shift_op_valid <= (state_nxt == HOLD);
            shift_busy     <= (state_nxt == SHIFT);
        end
    end

    // Input capture registers and the row counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_reg   <= '0;
            mask_reg <= '0;
            row_cnt  <= '0;
        end else if (capture) begin
            in_reg   <= shift_ip_char_matrix;
            mask_reg <= shift_ip_char_row_mask;
            row_cnt  <= '0;
        end else if (state == SHIFT) begin
            if (row_cnt == LAST_ROW) begin
                row_cnt <= '0;
            end else begin
                row_cnt <= row_cnt + RW'(1);
            end
        end
    end

    // Output matrix rows written one per cycle; mask published with the last row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_op_char_matrix   <= '0;
            shift_op_char_row_mask <= '0;
        end else if (state == SHIFT) begin
            shift_op_char_matrix[row_cnt] <= rot_row;
            if (row_cnt == LAST_ROW) begin
                shift_op_char_row_mask <= mask_reg;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stage.sv
module tb_shift_rows_stage;

    localparam int R = 16;
    localparam int C = 16;
    localparam int W = 16;

    typedef logic [R-1:0][C-1:0][W-1:0] mat_t;

    logic         clk = 1'b0;
    logic         reset;
    mat_t         ip_mat;
    logic [R-1:0] ip_mask;
    logic         ip_valid;
    logic         op_ready;
    logic         ip_ready_l, ip_ready_r;
    mat_t         op_mat_l, op_mat_r;
    logic [R-1:0] op_mask_l, op_mask_r;
    logic         op_valid_l, op_valid_r;
    logic         busy_l, busy_r;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state: 0 idle, 1 rotating, 2 holding result
    int           m_phase = 0;
    int           m_cnt = 0;
    mat_t         pend_l, pend_r, shown_l, shown_r;
    logic [R-1:0] pend_mask, shown_mask;

    always #5 clk = ~clk;

    shift_rows_stage #(.ROWS(R), .COLS(C), .CHAR_W(W), .SHIFT_DIR(0)) dut (
        .clk(clk), .reset(reset),
        .shift_ip_char_matrix(ip_mat), .shift_ip_char_row_mask(ip_mask),
        .shift_ip_valid(ip_valid), .shift_ip_ready(ip_ready_l),
        .shift_op_char_matrix(op_mat_l), .shift_op_char_row_mask(op_mask_l),
        .shift_op_valid(op_valid_l), .shift_op_ready(op_ready),
        .shift_busy(busy_l)
    );

    shift_rows_stage #(.ROWS(R), .COLS(C), .CHAR_W(W), .SHIFT_DIR(1)) dut_r (
        .clk(clk), .reset(reset),
        .shift_ip_char_matrix(ip_mat), .shift_ip_char_row_mask(ip_mask),
        .shift_ip_valid(ip_valid), .shift_ip_ready(ip_ready_r),
        .shift_op_char_matrix(op_mat_r), .shift_op_char_row_mask(op_mask_r),
        .shift_op_valid(op_valid_r), .shift_op_ready(op_ready),
        .shift_busy(busy_r)
    );

    function automatic mat_t rot(input mat_t m, input logic [R-1:0] mask, input int dir);
        mat_t o;
        int   s;
        for (int r = 0; r < R; r++) begin
            for (int j = 0; j < C; j++) begin
                if (mask[r]) begin
                    if (dir == 0) s = (j + r) % C;
                    else          s = (j - (r % C) + C) % C;
                    o[r][j] = m[r][s];
                end else begin
                    o[r][j] = m[r][j];
                end
            end
        end
        return o;
    endfunction

    function automatic mat_t pattern();
        mat_t m;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                m[i][j] = 16'(10 * i + j);
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                m[i][j] = 16'($urandom);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
        bit done;
        checks++;
        if (act !== exp) begin
            errors++;
            done = 1'b0;
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    if (!done && act[i][j] !== exp[i][j]) begin
                        done = 1'b1;
                        $display("FAIL %s: [%0d][%0d] got %0h expected %0h (t=%0t)",
                                 name, i, j, act[i][j], exp[i][j], $time);
                    end
        end
    endtask

    // Advance one clock; the model decides capture/accept from pre-edge inputs.
    task automatic cycle();
        bit acc, cap;
        acc = (m_phase == 2) && op_ready;
        cap = ip_valid && ((m_phase == 0) || acc);
        if (cap) begin
            pend_l    = rot(ip_mat, ip_mask, 0);
            pend_r    = rot(ip_mat, ip_mask, 1);
            pend_mask = ip_mask;
        end
        @(posedge clk);
        if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt == R) begin
                m_phase    = 2;
                shown_l    = pend_l;
                shown_r    = pend_r;
                shown_mask = pend_mask;
            end
        end else if (acc) begin
            m_phase = 0;
        end
        if (cap) begin
            m_phase = 1;
            m_cnt   = 0;
        end
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        #2;
        reset      = 1'b1;
        m_phase    = 0;
        m_cnt      = 0;
        shown_l    = '0;
        shown_r    = '0;
        shown_mask = '0;
        repeat (ncyc) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Cycles from capture until valid; an expired budget shows as a wrong latency.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (op_valid_l !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk(name, 64'(n), 64'd16);
    endtask

    task automatic send(input mat_t m, input logic [R-1:0] mask);
        ip_mat   = m;
        ip_mask  = mask;
        ip_valid = 1'b1;
        cycle();
        ip_valid = 1'b0;
    endtask

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        forever begin : cmp
            logic ev, eb, er;
            @(negedge clk);
            ev = !reset && (m_phase == 2);
            eb = !reset && (m_phase == 1);
            er = !reset && ((m_phase == 0) || ((m_phase == 2) && op_ready));
            chk("op_valid", {op_valid_l, op_valid_r}, {ev, ev});
            chk("busy", {busy_l, busy_r}, {eb, eb});
            chk("ip_ready", {ip_ready_l, ip_ready_r}, {er, er});
            if (reset || m_phase != 1) begin
                chk_mat("mat_left", op_mat_l, shown_l);
                chk_mat("mat_right", op_mat_r, shown_r);
                chk("op_mask", {op_mask_l, op_mask_r}, {shown_mask, shown_mask});
            end
        end
    end

    initial begin
        mat_t pat;
        bit   saw;
        pat        = pattern();
        shown_l    = '0;
        shown_r    = '0;
        shown_mask = '0;
        reset      = 1'b0;
        ip_mat     = rand_mat();
        ip_mask    = 16'($urandom);
        ip_valid   = 1'b1;
        op_ready   = 1'b1;

        // Reset with random inputs applied
        #1 reset = 1'b1;
        #21 reset = 1'b0;
        #1;
        chk("ready_after_reset", ip_ready_l, 1'b0 | 1'b1);
        ip_valid = 1'b0;
        repeat (3) cycle();
        chk("no_valid_after_reset", op_valid_l, 1'b0);

        // Full mask, left and right rotation
        send(pat, 16'hFFFF);
        wait_valid("latency_full");
        chk("l_0_0", op_mat_l[0][0], 16'd0);
        chk("l_1_0", op_mat_l[1][0], 16'd11);
        chk("l_1_15", op_mat_l[1][15], 16'd10);
        chk("l_15_0", op_mat_l[15][0], 16'd165);
        chk("l_15_1", op_mat_l[15][1], 16'd150);
        chk("mask_full", op_mask_l, 16'hFFFF);
        chk("r_1_0", op_mat_r[1][0], 16'd25);
        chk("r_2_0", op_mat_r[2][0], 16'd34);
        chk("r_15_0", op_mat_r[15][0], 16'd151);
        cycle();

        // Row 0 only: nothing actually moves
        send(pat, 16'h0001);
        wait_valid("latency_m1");
        chk_mat("mask1_identity", op_mat_l, pat);
        cycle();

        // Row 1 only
        send(pat, 16'h0002);
        wait_valid("latency_m2");
        chk("m2_1_0", op_mat_l[1][0], 16'd11);
        chk("m2_2_0", op_mat_l[2][0], 16'd20);
        cycle();

        // Zero mask still takes the full pass
        send(rand_mat(), 16'h0000);
        wait_valid("latency_zero_mask");
        cycle();

        // Backpressure then back-to-back capture
        op_ready = 1'b0;
        send(rand_mat(), 16'($urandom));
        wait_valid("latency_bp");
        repeat (5) cycle();
        chk("bp_ip_ready", ip_ready_l, 1'b0);
        chk("bp_valid", op_valid_l, 1'b1);
        op_ready = 1'b1;
        send(rand_mat(), 16'($urandom));
        chk("b2b_busy", busy_l, 1'b1);
        chk("b2b_valid_drop", op_valid_l, 1'b0);
        wait_valid("latency_b2b");
        cycle();

        // Reset while row 7 is next to be written
        send(rand_mat(), 16'hFFFF);
        repeat (7) cycle();
        do_reset(2);
        chk_mat("rst_mid_mat", op_mat_l, '0);
        saw = 1'b0;
        repeat (25) begin
            cycle();
            if (op_valid_l === 1'b1) saw = 1'b1;
        end
        chk("rst_no_emit", saw, 1'b0);
        send(pat, 16'hFFFF);
        wait_valid("latency_after_rst");
        chk("post_rst_15_0", op_mat_l[15][0], 16'd165);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ip_mat   = rand_mat();
            ip_mask  = 16'($urandom);
            ip_valid = ($urandom_range(0, 1) == 1);
            op_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
